// File: rtl/man_addsub_pipe.sv
// Two-stage sign-magnitude mantissa adder/subtractor with valid/ready flow control.
// Stage 1 latches operands and effective-operation flags; stage 2 forms the signed magnitude.
module man_addsub_pipe #(
    parameter int unsigned MAN_W = 23
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic             sign_a,
    input  logic [MAN_W-1:0] man_a,
    input  logic             sign_b,
    input  logic [MAN_W-1:0] man_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             res_sign,
    output logic [MAN_W:0]   res_mag,
    output logic             res_zero
);

    logic adv;

    logic             s1_valid_q;
    logic             s1_sign_a_q;
    logic             s1_eff_b_q;
    logic             s1_same_q;
    logic             s1_a_ge_q;
    logic [MAN_W-1:0] s1_man_a_q;
    logic [MAN_W-1:0] s1_man_b_q;

    logic           eff_b;
    logic [MAN_W:0] mag_d;
    logic           sign_d;
    logic           zero_d;

    // Both stages advance together whenever the output slot is free or being drained.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Subtraction is addition of B with its sign flipped.
    assign eff_b = sign_b ^ ~op;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
        end else if (adv) begin
            s1_valid_q <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv && in_valid) begin
            s1_sign_a_q <= sign_a;
            s1_eff_b_q  <= eff_b;
            s1_same_q   <= (sign_a == eff_b);
            s1_a_ge_q   <= (man_a >= man_b);
            s1_man_a_q  <= man_a;
            s1_man_b_q  <= man_b;
        end
    end

    // Unlike signs subtract the smaller magnitude from the larger, so no borrow occurs.
    always_comb begin
        mag_d  = '0;
        sign_d = 1'b0;
        if (s1_same_q) begin
            mag_d  = {1'b0, s1_man_a_q} + {1'b0, s1_man_b_q};
            sign_d = s1_sign_a_q;
        end else if (s1_a_ge_q) begin
            mag_d  = {1'b0, s1_man_a_q - s1_man_b_q};
            sign_d = s1_sign_a_q;
        end else begin
            mag_d  = {1'b0, s1_man_b_q - s1_man_a_q};
            sign_d = s1_eff_b_q;
        end
        zero_d = (mag_d == '0);
        if (zero_d) begin
            sign_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            res_sign  <= 1'b0;
            res_mag   <= '0;
            res_zero  <= 1'b0;
        end else if (adv) begin
            out_valid <= s1_valid_q;
            if (s1_valid_q) begin
                res_sign <= sign_d;
                res_mag  <= mag_d;
                res_zero <= zero_d;
            end
        end
    end

endmodule

// File: tb/tb_man_addsub_pipe.sv
// Self-checking bench for man_addsub_pipe: directed spec vectors, stall, reset and a
// randomized stream scored against a signed-integer reference model.
module tb_man_addsub_pipe;

    localparam int unsigned MAN_W = 23;
    localparam logic [MAN_W-1:0] MAX_MAN = {MAN_W{1'b1}};

    typedef struct packed {
        logic           sign;
        logic [MAN_W:0] mag;
        logic           zero;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic             sign_a;
    logic [MAN_W-1:0] man_a;
    logic             sign_b;
    logic [MAN_W-1:0] man_b;
    logic             out_valid;
    logic             out_ready;
    logic             res_sign;
    logic [MAN_W:0]   res_mag;
    logic             res_zero;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_out    = 0;
    bit   in_xfer;
    exp_t sb_q[$];

    man_addsub_pipe #(.MAN_W(MAN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .sign_a    (sign_a),
        .man_a     (man_a),
        .sign_b    (sign_b),
        .man_b     (man_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_sign  (res_sign),
        .res_mag   (res_mag),
        .res_zero  (res_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: treat operands as signed integers and do the arithmetic directly.
    function automatic exp_t model(input bit sa, input logic [MAN_W-1:0] ma, input bit sb,
                                   input logic [MAN_W-1:0] mb, input bit o);
        exp_t   e;
        longint va, vb, r, ar;
        va = sa ? -longint'(ma) : longint'(ma);
        vb = sb ? -longint'(mb) : longint'(mb);
        r  = o ? va + vb : va - vb;
        ar = (r < 0) ? -r : r;
        e.sign = (r < 0);
        e.mag  = (MAN_W + 1)'(ar);
        e.zero = (r == 0);
        return e;
    endfunction

    // Apply inputs away from the clock edge, then score the cycle's handshakes.
    task automatic tick(input bit iv, input bit sa, input logic [MAN_W-1:0] ma, input bit sb,
                        input logic [MAN_W-1:0] mb, input bit o, input bit ordy, input bit rst);
        exp_t e;
        @(negedge clk);
        reset     = rst;
        in_valid  = iv;
        sign_a    = sa;
        man_a     = ma;
        sign_b    = sb;
        man_b     = mb;
        op        = o;
        out_ready = ordy;
        #1;
        in_xfer = 1'b0;
        if (!rst) begin
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check("spurious_out", 64'(out_valid), 64'd0);
                end else begin
                    e = sb_q[0];
                    check("res_sign", 64'(res_sign), 64'(e.sign));
                    check("res_mag", 64'(res_mag), 64'(e.mag));
                    check("res_zero", 64'(res_zero), 64'(e.zero));
                    if (out_ready) begin
                        void'(sb_q.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(model(sa, ma, sb, mb, o));
                in_xfer = 1'b1;
            end
        end
    endtask

    task automatic idle(input bit ordy);
        tick(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, ordy, 1'b0);
    endtask

    // One isolated op with out_ready held high: checks the two-cycle latency and values.
    task automatic single_op(input string tag, input bit sa, input logic [MAN_W-1:0] ma,
                             input bit sb, input logic [MAN_W-1:0] mb, input bit o);
        tick(1'b1, sa, ma, sb, mb, o, 1'b1, 1'b0);
        check({tag, "_xfer"}, 64'(in_xfer), 64'd1);
        idle(1'b1);
        check({tag, "_lat1"}, 64'(out_valid), 64'd0);
        idle(1'b1);
        check({tag, "_lat2"}, 64'(out_valid), 64'd1);
    endtask

    function automatic logic [MAN_W-1:0] rand_man();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return MAX_MAN;
            2:       return MAN_W'($urandom_range(0, 7));
            default: return MAN_W'($urandom);
        endcase
    endfunction

    task automatic drain(input string tag);
        int budget;
        budget = 50;
        while (sb_q.size() != 0 && budget > 0) begin
            idle(1'b1);
            budget--;
        end
        check({tag, "_drained"}, 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        logic [MAN_W-1:0] ma, mb;
        int               idx, cyc, base;
        logic [MAN_W-1:0] stream_a[6];

        reset = 1'b1; in_valid = 1'b0; op = 1'b0; sign_a = 1'b0; man_a = '0;
        sign_b = 1'b0; man_b = '0; out_ready = 1'b1;
        repeat (3) tick(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1);

        idle(1'b1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_res_sign", 64'(res_sign), 64'd0);
        check("rst_res_mag", 64'(res_mag), 64'd0);
        check("rst_res_zero", 64'(res_zero), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        single_op("t1", 1'b0, 23'd5, 1'b0, 23'd3, 1'b1);
        check("t1_mag_const", 64'(res_mag), 64'd8);
        check("t1_sign_const", 64'(res_sign), 64'd0);
        single_op("t2a", 1'b0, 23'd3, 1'b0, 23'd5, 1'b0);
        check("t2a_sign_const", 64'(res_sign), 64'd1);
        check("t2a_mag_const", 64'(res_mag), 64'd2);
        single_op("t2b", 1'b1, 23'd5, 1'b0, 23'd3, 1'b1);
        check("t2b_sign_const", 64'(res_sign), 64'd1);
        single_op("t3a", 1'b1, 23'd7, 1'b1, 23'd7, 1'b0);
        check("t3a_zero_const", 64'(res_zero), 64'd1);
        check("t3a_sign_const", 64'(res_sign), 64'd0);
        single_op("t3b", 1'b0, 23'd0, 1'b1, 23'd0, 1'b1);
        check("t3b_zero_const", 64'(res_zero), 64'd1);
        check("t3b_sign_const", 64'(res_sign), 64'd0);
        single_op("t4", 1'b0, MAX_MAN, 1'b0, MAX_MAN, 1'b1);
        check("t4_mag_const", 64'(res_mag), 64'hFFFFFE);
        drain("directed");

        // Back-to-back stream of six ops with the output stalled in cycles 3-5.
        for (int i = 0; i < 6; i++) stream_a[i] = MAN_W'(100 * (i + 1));
        base = n_out;
        idx  = 0;
        cyc  = 1;
        while ((idx < 6 || sb_q.size() != 0) && cyc < 60) begin
            if (idx < 6) begin
                tick(1'b1, 1'b0, stream_a[idx], 1'b1, MAN_W'(idx + 1), 1'b1,
                     !(cyc >= 3 && cyc <= 5), 1'b0);
            end else begin
                idle(1'b1);
            end
            if (cyc >= 3 && cyc <= 5) check("stall_in_ready", 64'(in_ready), 64'd0);
            if (in_xfer) idx++;
            cyc++;
        end
        check("stream_all_in", 64'(idx), 64'd6);
        check("stream_all_out", 64'(n_out - base), 64'd6);

        // Reset with two ops in flight: neither may appear afterwards.
        tick(1'b1, 1'b0, 23'd11, 1'b0, 23'd1, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 23'd22, 1'b0, 23'd2, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        sb_q.delete();
        idle(1'b1);
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_in_ready", 64'(in_ready), 64'd1);
        idle(1'b1);
        check("rst_mid_out_valid2", 64'(out_valid), 64'd0);
        single_op("post_rst", 1'b1, 23'd9, 1'b0, 23'd4, 1'b0);
        check("post_rst_mag_const", 64'(res_mag), 64'd13);
        drain("reset");

        // Randomized traffic with random back-pressure.
        base = n_out;
        idx  = 0;
        for (int i = 0; i < 3000; i++) begin
            ma = rand_man();
            mb = ($urandom_range(0, 4) == 0) ? ma : rand_man();
            tick(($urandom_range(0, 9) < 7), 1'($urandom), ma, 1'($urandom), mb, 1'($urandom),
                 ($urandom_range(0, 9) < 7), 1'b0);
            if (in_xfer) idx++;
        end
        drain("random");
        check("random_count", 64'(n_out - base), 64'(idx));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
